// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the multi-cycle RISC-V core and its byte-serial
// load/store unit: opcodes, control states, memory width decode.
package mem_access_unit_pkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_OP     = 7'b0110011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111
   } OpCode;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      EXECUTE,
      READ_MEMORY,
      WRITE_MEMORY,
      WRITEBACK
   } ControlState;

   // funct3 encoding of the load/store width
   typedef enum logic [2:0] {
      MW_B  = 3'b000,
      MW_H  = 3'b001,
      MW_W  = 3'b010,
      MW_BU = 3'b100,
      MW_HU = 3'b101
   } MemWidth;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } LsuState;

   function automatic logic [2:0] width_bytes(MemWidth w);
      case (w)
         MW_B, MW_BU: return 3'd1;
         MW_H, MW_HU: return 3'd2;
         default:     return 3'd4;
      endcase
   endfunction

   // Unsigned widths only make sense for loads.
   function automatic logic width_legal(logic [2:0] f3, logic store);
      case (f3)
         3'b000, 3'b001, 3'b010: return 1'b1;
         3'b100, 3'b101:         return !store;
         default:                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of an assembled little-endian load value.
module load_extend
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] value,
   input  MemWidth     width,
   output logic [31:0] result
);

   // select the extension by load width
   always_comb begin
      result = value;
      case (width)
         MW_B:    result = {{24{value[7]}}, value[7:0]};
         MW_H:    result = {{16{value[15]}}, value[15:0]};
         MW_BU:   result = {24'h000000, value[7:0]};
         MW_HU:   result = {16'h0000, value[15:0]};
         default: result = value;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-serial load/store unit: one byte per clock over an 8-bit memory port.
// Handshake: start (with is_store/funct3/addr/wdata) is taken only in IDLE;
// busy is high exactly while bytes move; done pulses one cycle at the end,
// with err when the width encoding was illegal. rdata holds until the next
// accepted start.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   LsuState     state_q, state_d;
   logic [31:0] addr_q, wdata_q, asm_q, asm_d, ext_val, rdata_q;
   MemWidth     width_q;
   logic        store_q, err_q;
   logic [1:0]  idx_q, last_q;
   logic [2:0]  last_w;
   logic        accept, req_legal, at_last;

   assign req_legal = width_legal(funct3, is_store);
   assign accept    = (state_q == IDLE) && start;
   assign at_last   = (idx_q == last_q);
   assign last_w    = width_bytes(MemWidth'(funct3)) - 3'd1;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = req_legal ? ACCESS : DONE;
         ACCESS:  if (at_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // merge the incoming byte so the last byte can be extended in the same cycle
   always_comb begin
      asm_d = asm_q;
      asm_d[8*idx_q +: 8] = mem_rdata;
   end

   load_extend u_load_extend (
      .value  (asm_d),
      .width  (width_q),
      .result (ext_val)
   );

   // request capture, byte sequencing and load assembly
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         width_q <= MW_B;
         store_q <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         last_q  <= '0;
         asm_q   <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         addr_q  <= addr;
         wdata_q <= wdata;
         width_q <= MemWidth'(funct3);
         store_q <= is_store;
         err_q   <= !req_legal;
         idx_q   <= '0;
         last_q  <= last_w[1:0];
         asm_q   <= '0;
         if (!req_legal) rdata_q <= '0;
      end else if (state_q == ACCESS) begin
         if (!store_q) asm_q <= asm_d;
         if (at_last) begin
            if (!store_q) rdata_q <= ext_val;
         end else begin
            idx_q <= idx_q + 2'd1;
         end
      end
   end

   // status and memory port; the port is quiet outside ACCESS
   always_comb begin
      busy      = (state_q == ACCESS);
      done      = (state_q == DONE);
      err       = (state_q == DONE) && err_q;
      rdata     = rdata_q;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (state_q == ACCESS) begin
         mem_addr = addr_q + {30'd0, idx_q};
         if (store_q) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q[8*idx_q +: 8];
         end
      end
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Byte-serial load/store unit between the multi-cycle RISC-V control FSM and byte-wide data memory. It executes one LB/LH/LW/LBU/LHU/SB/SH/SW per request over an 8-bit memory port, one byte per clock. On loads it assembles the result little-endian and sign- or zero-extends it. It replaces the control FSM's direct word access to `mem` in its READ_MEMORY/WRITE_MEMORY states.

## Interface
- No parameters; address width fixed at 32.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request strobe; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load; sampled with `start`
- `funct3`  in  3  RISC-V width field; sampled with `start`
- `addr`  in  32  byte address (ALU result); sampled with `start`
- `wdata`  in  32  store data (rs2 value); sampled with `start`
- `busy`  out  1  high while memory bytes are being transferred
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  high with `done` if `funct3` was illegal
- `rdata`  out  32  extended load result; held until the next accepted `start`
- `mem_addr`  out  32  byte address to memory
- `mem_we`  out  1  byte write enable
- `mem_wdata`  out  8  byte to write
- `mem_rdata`  in  8  byte read from `mem_addr`, combinational in the same cycle

## Operation
- Width decode (package enum `MemWidth`):
  - 000 byte, signed
  - 001 half, signed
  - 010 word
  - 100 byte, unsigned
  - 101 half, unsigned
- Illegal encodings: 011, 110, 111. For stores, 100 and 101 are also illegal.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE + `start`, legal: latch `addr`, `wdata`, width and `is_store`; set `idx`=0; set `last` = bytes−1. Go to ACCESS.
  - IDLE + `start`, illegal: go to DONE with `err` set. No memory access occurs, and `rdata` is cleared to 0.
  - ACCESS: drive `mem_addr` = latched addr + `idx`, modulo 2^32 (wrap-around is required).
    - Load: capture `mem_rdata` into byte lane `idx` of the assembly register.
    - Store: `mem_we`=1 and `mem_wdata` = wdata[8·idx +: 8].
    - When `idx`==`last`, go to DONE; otherwise increment `idx`.
  - DONE: `done`=1 for one cycle. On a load, `rdata` is updated on entry to DONE with the extended assembly value. Then return to IDLE unconditionally.
- `start` is ignored in ACCESS and DONE.
- No alignment restriction; misaligned accesses are legal and byte-serial.
- Extension rule:
  - Signed byte/half replicate bit 7/15 into the upper bits.
  - Unsigned byte/half zero-fill the upper bits.
  - Word passes through unchanged.
- Store `rdata` is left unchanged.
- Outside ACCESS: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Latency: `start` accepted at edge N. ACCESS occupies cycles N+1 … N+bytes, and `done` is high in cycle N+bytes+1.
  - LW/SW: `done` 5 cycles after `start`.
  - LB/SB: `done` 2 cycles after `start`.
  - Illegal request: `done`+`err` 1 cycle after `start`.
- `busy`=1 exactly in ACCESS cycles and 0 in DONE. The control FSM stalls its state register while `busy|start`.
- Next `start` may be asserted in the cycle after DONE (back-to-back throughput = bytes+2 cycles).
- Reset mid-operation:
  - Next state is IDLE, and `mem_we` drops to 0 in the following cycle.
  - Bytes already written stay written (no rollback).
  - `rdata` is cleared to 0 and no `done` is issued.
- `rst` has priority over `start` in the same cycle.

## Structure
- Shared package (with `OpCode`, `ControlState`) holds:
  - `MemWidth` enum (funct3 encoding)
  - `LsuState` enum {IDLE, ACCESS, DONE}
  - function `width_bytes(MemWidth)` → 1/2/4
- One combinational sub-module, `load_extend`: inputs 32-bit assembled value and `MemWidth`; output 32-bit extended result. Instantiated once, verified standalone.

## Test plan
- mem[0x80..0x83]=88,77,66,55 hex; LW addr 0x80 → four ACCESS cycles with `mem_addr` 0x80..0x83, `done` at cycle 5, `rdata`=0x55667788, `err`=0.
- Same memory: LB 0x80 → `rdata`=0xFFFFFF88. LBU 0x80 → 0x00000088. LH 0x81 → 0x00006677. LHU 0x82 → 0x00005566.
- SW addr 0x7B, `wdata`=0x00000058 → `mem_we` high 4 cycles; mem[0x7B]=0x58, mem[0x7C..0x7E]=0; `rdata` unchanged.
- SH addr 0xFFFFFFFF, `wdata`=0x0000BEEF → mem[0xFFFFFFFF]=0xEF, mem[0x0]=0xBE (address wrap).
- `funct3`=011 load, and `funct3`=100 store → `done`+`err` one cycle after `start`, `mem_we` never high, `rdata`=0.
- LW started, `rst` asserted in the 2nd ACCESS cycle → next cycle: `busy`=0, `mem_we`=0, `rdata`=0, no `done`. A `start` held high during ACCESS is ignored and is not accepted afterward unless still high in IDLE.
